// File: rtl/arb_client_ctrl_if.sv
// Bundle between the client controller and the LSB-priority arbiter plus its clients.
// The controller uses the slave modport; the environment driving req/g uses master.
interface arb_client_ctrl_if #(
  parameter int n = 8,
  parameter int m = 3
);
  logic [n-1:0] req;
  logic [n-1:0] r;
  logic [n-1:0] g;
  logic         valid;
  logic [n-1:0] cur;
  logic [m-1:0] idx;
  logic [n-1:0] done;
  logic         err;

  modport master (output req, g, input r, valid, cur, idx, done, err);
  modport slave  (input req, g, output r, valid, cur, idx, done, err);
endinterface

// File: rtl/arb_client_ctrl.sv
// Client-side controller for a combinational LSB-priority arbiter: latches request
// pulses, presents them as r, and serves each granted client for a HOLD-cycle window.
module arb_client_ctrl #(
  parameter int n    = 8,
  parameter int m    = 3,
  parameter int HOLD = 4,
  parameter int CW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  arb_client_ctrl_if.slave bus
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [n-1:0]   pending;
  logic [n-1:0]   cur_q;
  logic [m-1:0]   idx_q;

  logic [n-1:0]   grant;
  logic [n-1:0]   clear_mask;
  logic [m-1:0]   enc;
  logic           last;
  logic           accept;

  // A grant for a client that is not pending is meaningless and is masked off.
  assign grant      = bus.g & pending;
  assign last       = (state == SERVE) && (cnt == '0);
  assign accept     = ((state == IDLE) || last) && (|grant);
  assign clear_mask = accept ? grant : '0;

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    enc = '0;
    for (int i = 0; i < n; i++) begin
      if (grant[i]) enc = m'(i);
    end
  end

  always_comb begin
    bus.done = '0;
    if (last) bus.done = cur_q;
  end

  // A re-request for a client being accepted this cycle is a fresh request, not an error.
  assign bus.err   = |(bus.req & pending & ~clear_mask);
  assign bus.r     = pending;
  assign bus.valid = (state == SERVE);
  assign bus.cur   = cur_q;
  assign bus.idx   = idx_q;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      cur_q   <= '0;
      idx_q   <= '0;
    end else begin
      pending <= (pending & ~clear_mask) | bus.req;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= SERVE;
            cur_q <= grant;
            idx_q <= enc;
            cnt   <= CW'(HOLD - 1);
          end
        end
        SERVE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (accept) begin
            cur_q <= grant;
            idx_q <= enc;
            cnt   <= CW'(HOLD - 1);
          end else begin
            state <= IDLE;
            cur_q <= '0;
            idx_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_client_ctrl.sv
// Scoreboard bench for arb_client_ctrl: a HOLD=4 instance and a HOLD=1 instance,
// each fed by a behavioural LSB-priority arbiter.
module tb_arb_client_ctrl;

  typedef struct packed {
    logic [7:0] cur;
    logic [2:0] idx;
    bit         last;
    bit         from_idle;
  } svc_t;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  bit   mon_en  = 1'b0;
  bit   exp_err [2];
  bit   prev_valid [2];
  svc_t qa[$];
  svc_t qb[$];

  always #5 clk = ~clk;

  arb_client_ctrl_if #(.n(8), .m(3)) bus_a ();
  arb_client_ctrl_if #(.n(8), .m(3)) bus_b ();

  // Arbiter model: lowest set bit of r wins.
  assign bus_a.g = bus_a.r & (~bus_a.r + 8'd1);
  assign bus_b.g = bus_b.r & (~bus_b.r + 8'd1);

  arb_client_ctrl #(.n(8), .m(3), .HOLD(4), .CW(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  arb_client_ctrl #(.n(8), .m(3), .HOLD(1), .CW(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_svc(input int k, input logic [7:0] cur, input logic [2:0] idx,
                          input int cycles, input bit complete, input bit from_idle);
    svc_t s;
    for (int i = 0; i < cycles; i++) begin
      s.cur       = cur;
      s.idx       = idx;
      s.last      = complete && (i == cycles - 1);
      s.from_idle = from_idle && (i == 0);
      if (k == 0) qa.push_back(s);
      else        qb.push_back(s);
    end
  endtask

  task automatic monitor_one(input int k, input logic valid, input logic [7:0] cur,
                             input logic [2:0] idx, input logic [7:0] done, input logic err);
    svc_t e;
    bit   have;
    check(err == exp_err[k], $sformatf("err[%0d]", k), 32'(err), 32'(exp_err[k]));
    if (valid) begin
      have = (k == 0) ? (qa.size() > 0) : (qb.size() > 0);
      if (!have) begin
        check(1'b0, $sformatf("unexpected_service[%0d]", k), 32'(cur), 32'h0);
      end else begin
        if (k == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        check(cur == e.cur, $sformatf("cur[%0d]", k), 32'(cur), 32'(e.cur));
        check(idx == e.idx, $sformatf("idx[%0d]", k), 32'(idx), 32'(e.idx));
        check(done == (e.last ? e.cur : 8'h00), $sformatf("done[%0d]", k),
              32'(done), 32'(e.last ? e.cur : 8'h00));
        check(prev_valid[k] == !e.from_idle, $sformatf("window_gap[%0d]", k),
              32'(prev_valid[k]), 32'(!e.from_idle));
      end
    end else begin
      check(cur == 8'h00 && idx == 3'd0, $sformatf("idle_cur_idx[%0d]", k), {21'd0, idx, cur}, 32'h0);
      check(done == 8'h00, $sformatf("idle_done[%0d]", k), 32'(done), 32'h0);
    end
    prev_valid[k] = valid;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor_one(0, bus_a.valid, bus_a.cur, bus_a.idx, bus_a.done, bus_a.err);
      monitor_one(1, bus_b.valid, bus_b.cur, bus_b.idx, bus_b.done, bus_b.err);
    end
  end

  task automatic drain(input int cycles, input string name);
    repeat (cycles) tick();
    check(qa.size() == 0, {name, "_drain_a"}, 32'(qa.size()), 32'd0);
    check(qb.size() == 0, {name, "_drain_b"}, 32'(qb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_a.req = 8'h00;
    bus_b.req = 8'h00;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
    prev_valid[0] = 1'b0;
    prev_valid[1] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check(bus_a.r == 8'h00, "reset_r", 32'(bus_a.r), 32'h0);
    check(bus_a.valid == 1'b0, "reset_valid", 32'(bus_a.valid), 32'h0);
    check(bus_a.cur == 8'h00 && bus_a.idx == 3'd0, "reset_cur_idx", 32'(bus_a.cur), 32'h0);
    check(bus_b.valid == 1'b0, "reset_valid_b", 32'(bus_b.valid), 32'h0);
    mon_en = 1'b1;

    // Single request: client 2.
    bus_a.req = 8'h04;
    push_svc(0, 8'h04, 3'd2, 4, 1'b1, 1'b1);
    tick();
    bus_a.req = 8'h00;
    check(bus_a.r == 8'h04, "t1_r_pending", 32'(bus_a.r), 32'h04);
    tick();
    check(bus_a.r == 8'h00, "t1_r_cleared", 32'(bus_a.r), 32'h00);
    drain(8, "t1");

    // Two clients at once: 4 then 7 back-to-back.
    bus_a.req = 8'h90;
    push_svc(0, 8'h10, 3'd4, 4, 1'b1, 1'b1);
    push_svc(0, 8'h80, 3'd7, 4, 1'b1, 1'b0);
    tick();
    bus_a.req = 8'h00;
    check(bus_a.r == 8'h90, "t2_r_pending", 32'(bus_a.r), 32'h90);
    drain(12, "t2");

    // Duplicate request for a pending client while client 0 holds the arbiter.
    bus_a.req = 8'h01;
    push_svc(0, 8'h01, 3'd0, 4, 1'b1, 1'b1);
    push_svc(0, 8'h02, 3'd1, 4, 1'b1, 1'b0);
    tick();
    bus_a.req = 8'h02;
    tick();
    bus_a.req = 8'h02;
    exp_err[0] = 1'b1;
    tick();
    bus_a.req = 8'h00;
    exp_err[0] = 1'b0;
    drain(12, "t3");

    // Re-request in the accept cycle: client 3 served twice, no error.
    bus_a.req = 8'h08;
    push_svc(0, 8'h08, 3'd3, 4, 1'b1, 1'b1);
    push_svc(0, 8'h08, 3'd3, 4, 1'b1, 1'b0);
    tick();
    bus_a.req = 8'h08;
    tick();
    bus_a.req = 8'h00;
    check(bus_a.r == 8'h08, "t4_r_kept", 32'(bus_a.r), 32'h08);
    drain(12, "t4");

    // Reset in the second service cycle aborts everything.
    bus_a.req = 8'h30;
    push_svc(0, 8'h10, 3'd4, 2, 1'b0, 1'b1);
    tick();
    bus_a.req = 8'h00;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check(bus_a.valid == 1'b0, "t5_valid", 32'(bus_a.valid), 32'h0);
    check(bus_a.r == 8'h00, "t5_r", 32'(bus_a.r), 32'h0);
    check(bus_a.cur == 8'h00, "t5_cur", 32'(bus_a.cur), 32'h0);
    check(bus_a.idx == 3'd0, "t5_idx", 32'(bus_a.idx), 32'h0);
    drain(10, "t5");

    // HOLD=1: one client per cycle, done every cycle.
    bus_b.req = 8'h07;
    push_svc(1, 8'h01, 3'd0, 1, 1'b1, 1'b1);
    push_svc(1, 8'h02, 3'd1, 1, 1'b1, 1'b0);
    push_svc(1, 8'h04, 3'd2, 1, 1'b1, 1'b0);
    tick();
    bus_b.req = 8'h00;
    check(bus_b.r == 8'h07, "t6_r_pending", 32'(bus_b.r), 32'h07);
    drain(8, "t6");

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
